// File: rtl/servile_spi_ram_if.sv
// Wishbone-style memory bus between the servile arbiter and the SPI SRAM bridge.
interface servile_spi_ram_if;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic [31:0] rdt;
  logic        ack;

  modport master (output adr, dat, sel, we, stb, input rdt, ack);
  modport slave  (input adr, dat, sel, we, stb, output rdt, ack);
endinterface

// File: rtl/servile_spi_ram.sv
// Wishbone to 23LC-style SPI SRAM bridge (mode 0, READ 0x03 / WRITE 0x02).
// Define SERVILE_SPI_RAM_SEL_MERGE_EN to merge contiguous byte enables into one WRITE.
module servile_spi_ram #(
  parameter int AW      = 17,
  parameter int CLK_DIV = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  servile_spi_ram_if.slave   wb,
  output logic               o_spi_sck,
  output logic               o_spi_cs_n,
  output logic               o_spi_mosi,
  input  logic               i_spi_miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, GAP, ACK} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic            sck_q, sck_d;
  logic            cs_n_q, cs_n_d;
  logic [63:0]     tx_q, tx_d;
  logic [31:0]     rx_q, rx_d;
  logic [4:0]      bit_q, bit_d;
  logic [2:0]      nbytes_q, nbytes_d;
  logic [3:0]      pend_q, pend_d;
  logic [AW-3:0]   adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic            we_q, we_d;
  logic            ack_q, ack_d;
  logic [31:0]     rdt_q, rdt_d;

  logic [3:0]      run_src;
  logic [3:0]      run_m;
  logic [1:0]      run_lo;
  logic            unused_adr;

  // Bytes serviced by the next WRITE: lowest set bit, plus its contiguous neighbours when merging.
  function automatic logic [3:0] run_mask(input logic [3:0] pend);
    logic [3:0] m;
    logic       open_run;
    m        = '0;
    open_run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (pend[i] && open_run) begin
        m[i] = 1'b1;
`ifndef SERVILE_SPI_RAM_SEL_MERGE_EN
        open_run = 1'b0;
`endif
      end else if (m != 4'b0000) begin
        open_run = 1'b0;
      end
    end
    return m;
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] m);
    logic [1:0] lo;
    lo = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) lo = 2'(i);
    end
    return lo;
  endfunction

  function automatic logic [2:0] byte_count(input logic [3:0] m);
    return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
  endfunction

  function automatic logic [63:0] build_tx(input logic we, input logic [AW-3:0] word,
                                           input logic [31:0] dat, input logic [1:0] lo);
    logic [23:0] addr;
    logic [31:0] sh;
    addr = 24'({word, lo});
    sh   = we ? (dat >> {lo, 3'b000}) : 32'h0;
    return {(we ? 8'h02 : 8'h03), addr, sh[7:0], sh[15:8], sh[23:16], sh[31:24]};
  endfunction

  assign run_src    = (state_q == IDLE) ? wb.sel : pend_q;
  assign run_m      = run_mask(run_src);
  assign run_lo     = low_index(run_m);
  assign unused_adr = ^{wb.adr[31:AW], wb.adr[1:0]};

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    sck_d    = sck_q;
    cs_n_d   = cs_n_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    bit_d    = bit_q;
    nbytes_d = nbytes_q;
    pend_d   = pend_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    we_d     = we_q;
    ack_d    = 1'b0;
    rdt_d    = rdt_q;

    case (state_q)
      IDLE: begin
        if (wb.stb && !ack_q) begin
          adr_d  = wb.adr[AW-1:2];
          dat_d  = wb.dat;
          we_d   = wb.we;
          div_d  = '0;
          sck_d  = 1'b0;
          bit_d  = '0;
          pend_d = '0;
          if (!wb.we) begin
            tx_d     = build_tx(1'b0, wb.adr[AW-1:2], wb.dat, 2'd0);
            nbytes_d = 3'd4;
            cs_n_d   = 1'b0;
            state_d  = CMD;
          end else if (wb.sel == 4'b0000) begin
            state_d = ACK;
          end else begin
            tx_d     = build_tx(1'b1, wb.adr[AW-1:2], wb.dat, run_lo);
            nbytes_d = byte_count(run_m);
            pend_d   = wb.sel & ~run_m;
            cs_n_d   = 1'b0;
            state_d  = CMD;
          end
        end
      end

      CMD, ADDR, DATA: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
            if (state_q == DATA && !we_q) rx_d = {rx_q[30:0], i_spi_miso};
          end else begin
            sck_d = 1'b0;
            tx_d  = {tx_q[62:0], 1'b0};
            bit_d = bit_q + 5'd1;
            if (state_q == CMD && bit_q == 5'd7) begin
              bit_d   = '0;
              state_d = ADDR;
            end else if (state_q == ADDR && bit_q == 5'd23) begin
              bit_d   = '0;
              state_d = DATA;
            end else if (state_q == DATA && bit_q == 5'({nbytes_q, 3'b000} - 6'd1)) begin
              bit_d   = '0;
              tx_d    = '0;
              cs_n_d  = 1'b1;
              state_d = GAP;
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      GAP: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (pend_q != 4'b0000) begin
            tx_d     = build_tx(1'b1, adr_q, dat_q, run_lo);
            nbytes_d = byte_count(run_m);
            pend_d   = pend_q & ~run_m;
            cs_n_d   = 1'b0;
            state_d  = CMD;
          end else begin
            state_d = ACK;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      ACK: begin
        ack_d   = 1'b1;
        if (!we_q) rdt_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Reset drops SCK and raises CS_n immediately, abandoning any transaction without an ack.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      sck_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      tx_q     <= '0;
      rx_q     <= '0;
      bit_q    <= '0;
      nbytes_q <= '0;
      pend_q   <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      ack_q    <= 1'b0;
      rdt_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      sck_q    <= sck_d;
      cs_n_q   <= cs_n_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      bit_q    <= bit_d;
      nbytes_q <= nbytes_d;
      pend_q   <= pend_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      we_q     <= we_d;
      ack_q    <= ack_d;
      rdt_q    <= rdt_d;
    end
  end

  assign o_spi_sck  = sck_q;
  assign o_spi_cs_n = cs_n_q;
  assign o_spi_mosi = tx_q[63];
  assign wb.rdt     = rdt_q;
  assign wb.ack     = ack_q;

endmodule

// File: tb/tb_servile_spi_ram.sv
// Directed bench for servile_spi_ram with a behavioural 23LC-style SPI SRAM model.
// Expectations follow SERVILE_SPI_RAM_SEL_MERGE_EN when it is defined.
module tb_servile_spi_ram;
  localparam int CLK_DIV = 1;
`ifdef SERVILE_SPI_RAM_SEL_MERGE_EN
  localparam int WR4_TXNS = 1;
  localparam int WR4_LAT  = 131;
  localparam int S0110_TXNS = 1;
  localparam int S0110_LAT  = 99;
`else
  localparam int WR4_TXNS = 4;
  localparam int WR4_LAT  = 326;
  localparam int S0110_TXNS = 2;
  localparam int S0110_LAT  = 164;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic sck, cs_n, mosi;
  logic miso = 1'b0;

  servile_spi_ram_if wb();

  servile_spi_ram #(.AW(17), .CLK_DIV(CLK_DIV)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .wb        (wb),
    .o_spi_sck (sck),
    .o_spi_cs_n(cs_n),
    .o_spi_mosi(mosi),
    .i_spi_miso(miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  mem [0:4095];
  int          spi_bits = 0;
  logic [7:0]  spi_cmd  = 8'h00;
  logic [23:0] spi_addr = 24'h0;
  logic [7:0]  spi_byte = 8'h00;
  logic [11:0] wr_ptr   = 12'h0;
  int          txn_count = 0;
  logic [23:0] txn_addr [$];
  int          gaps [$];
  int          hi_run = 0;

  // SRAM model: CS_n falling starts a transaction (SCK is low then), rising SCK shifts MOSI in.
  always @(negedge cs_n or posedge sck) begin
    if (!sck) begin
      spi_bits = 0;
      txn_count++;
    end else if (!cs_n) begin
      if (spi_bits < 8) begin
        spi_cmd = {spi_cmd[6:0], mosi};
      end else if (spi_bits < 32) begin
        spi_addr = {spi_addr[22:0], mosi};
        if (spi_bits == 31) begin
          txn_addr.push_back(spi_addr);
          wr_ptr = spi_addr[11:0];
        end
      end else begin
        spi_byte = {spi_byte[6:0], mosi};
        if ((spi_bits % 8) == 7 && spi_cmd == 8'h02) begin
          mem[wr_ptr] = spi_byte;
          wr_ptr = wr_ptr + 12'd1;
        end
      end
      spi_bits++;
    end
  end

  always @(negedge sck) begin
    logic [7:0] rd_byte;
    logic [2:0] rd_bit;
    if (!cs_n && spi_cmd == 8'h03 && spi_bits >= 32) begin
      rd_byte = mem[spi_addr[11:0] + 12'((spi_bits - 32) / 8)];
      rd_bit  = 3'(7 - ((spi_bits - 32) % 8));
      miso    = rd_byte[rd_bit];
    end
  end

  always @(posedge clk) begin
    if (cs_n) begin
      hi_run++;
    end else begin
      if (hi_run > 0) gaps.push_back(hi_run);
      hi_run = 0;
    end
  end

  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdata, output int lat);
    @(negedge clk);
    wb.we  = we;
    wb.adr = adr;
    wb.dat = dat;
    wb.sel = sel;
    wb.stb = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (wb.ack !== 1'b1 && lat < 1000);
    rdata  = wb.rdt;
    wb.stb = 1'b0;
    n_checks++;
    if (wb.ack !== 1'b1) $display("[TB] FAIL ack_timeout: ack=%b required 1 (adr %h)", wb.ack, adr);
    else n_pass++;
  endtask

  task automatic test_reset();
    wb.stb = 1'b0; wb.we = 1'b0; wb.adr = '0; wb.dat = '0; wb.sel = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (wb.ack !== 1'b0) $display("[TB] FAIL reset_ack: got %b required 0", wb.ack); else n_pass++;
    n_checks++; if (wb.rdt !== 32'h0) $display("[TB] FAIL reset_rdt: got %h required 0", wb.rdt); else n_pass++;
    n_checks++; if (sck !== 1'b0) $display("[TB] FAIL reset_sck: got %b required 0", sck); else n_pass++;
    n_checks++; if (cs_n !== 1'b1) $display("[TB] FAIL reset_cs_n: got %b required 1", cs_n); else n_pass++;
    n_checks++; if (mosi !== 1'b0) $display("[TB] FAIL reset_mosi: got %b required 0", mosi); else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    int lat, t0;
    t0 = txn_count;
    wb_access(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, rd, lat);
    n_checks++; if (txn_count - t0 !== WR4_TXNS) $display("[TB] FAIL wr4_txns: got %0d required %0d", txn_count - t0, WR4_TXNS); else n_pass++;
    n_checks++; if (lat !== WR4_LAT) $display("[TB] FAIL wr4_latency: got %0d required %0d", lat, WR4_LAT); else n_pass++;
    n_checks++;
    if ({mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]} !== 32'hDEADBEEF)
      $display("[TB] FAIL wr4_mem: got %h required deadbeef", {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]});
    else n_pass++;
    wb_access(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
    n_checks++; if (rd !== 32'hDEADBEEF) $display("[TB] FAIL rd_data: got %h required deadbeef", rd); else n_pass++;
    n_checks++; if (lat !== 131) $display("[TB] FAIL rd_latency: got %0d required 131", lat); else n_pass++;
  endtask

  task automatic test_partial_write();
    logic [31:0] rd;
    int lat, t0, a0;
    wb_access(1'b1, 32'h104, 32'h11223344, 4'hF, rd, lat);
    t0 = txn_count;
    a0 = txn_addr.size();
    wb_access(1'b1, 32'h104, 32'h00AA0000, 4'b0100, rd, lat);
    n_checks++; if (txn_count - t0 !== 1) $display("[TB] FAIL byte2_txns: got %0d required 1", txn_count - t0); else n_pass++;
    n_checks++;
    if (txn_addr.size() <= a0 || txn_addr[a0] !== 24'h000106)
      $display("[TB] FAIL byte2_addr: got %h required 000106", (txn_addr.size() > a0) ? txn_addr[a0] : 24'hxxxxxx);
    else n_pass++;
    n_checks++; if (lat !== 83) $display("[TB] FAIL byte2_latency: got %0d required 83", lat); else n_pass++;
    wb_access(1'b0, 32'h104, 32'h0, 4'h0, rd, lat);
    n_checks++; if (rd !== 32'h11AA3344) $display("[TB] FAIL byte2_readback: got %h required 11aa3344", rd); else n_pass++;
  endtask

  task automatic test_split_runs();
    logic [31:0] rd;
    int lat, t0, a0, g0, gap;
    t0 = txn_count; a0 = txn_addr.size(); g0 = gaps.size();
    wb_access(1'b1, 32'h200, 32'h44332211, 4'b1001, rd, lat);
    n_checks++; if (txn_count - t0 !== 2) $display("[TB] FAIL s1001_txns: got %0d required 2", txn_count - t0); else n_pass++;
    n_checks++;
    if (txn_addr.size() < a0 + 2 || txn_addr[a0] !== 24'h000200 || txn_addr[a0+1] !== 24'h000203)
      $display("[TB] FAIL s1001_addrs: got %0d txns required 000200,000203", txn_addr.size() - a0);
    else n_pass++;
    gap = (gaps.size() > g0 + 1) ? gaps[g0+1] : -1;
    n_checks++; if (gap !== CLK_DIV) $display("[TB] FAIL s1001_gap: got %0d required %0d", gap, CLK_DIV); else n_pass++;
    n_checks++; if (lat !== 164) $display("[TB] FAIL s1001_latency: got %0d required 164", lat); else n_pass++;
    n_checks++;
    if (mem[12'h200] !== 8'h11 || mem[12'h203] !== 8'h44)
      $display("[TB] FAIL s1001_mem: got %h,%h required 11,44", mem[12'h200], mem[12'h203]);
    else n_pass++;
    t0 = txn_count; a0 = txn_addr.size();
    wb_access(1'b1, 32'h200, 32'h88776655, 4'b0110, rd, lat);
    n_checks++; if (txn_count - t0 !== S0110_TXNS) $display("[TB] FAIL s0110_txns: got %0d required %0d", txn_count - t0, S0110_TXNS); else n_pass++;
    n_checks++;
    if (txn_addr.size() <= a0 || txn_addr[a0] !== 24'h000201)
      $display("[TB] FAIL s0110_addr: got %0d txns required first at 000201", txn_addr.size() - a0);
    else n_pass++;
    n_checks++; if (lat !== S0110_LAT) $display("[TB] FAIL s0110_latency: got %0d required %0d", lat, S0110_LAT); else n_pass++;
    wb_access(1'b0, 32'h200, 32'h0, 4'h0, rd, lat);
    n_checks++; if (rd !== 32'h44776611) $display("[TB] FAIL s0110_readback: got %h required 44776611", rd); else n_pass++;
  endtask

  task automatic test_sel_zero();
    logic [31:0] rd;
    int lat, t0, g0;
    t0 = txn_count; g0 = gaps.size();
    wb_access(1'b1, 32'h300, 32'hCAFEF00D, 4'h0, rd, lat);
    n_checks++; if (lat !== 2) $display("[TB] FAIL sel0_latency: got %0d required 2", lat); else n_pass++;
    n_checks++; if (txn_count - t0 !== 0 || gaps.size() !== g0) $display("[TB] FAIL sel0_cs_activity: got %0d txns required 0", txn_count - t0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int lat, acks;
    @(negedge clk);
    wb.we = 1'b0; wb.adr = 32'h100; wb.sel = 4'h0; wb.stb = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (cs_n !== 1'b0) $display("[TB] FAIL mid_cs_active: got %b required 0", cs_n); else n_pass++;
    rst_n = 1'b0;
    wb.stb = 1'b0;
    #1;
    n_checks++; if (cs_n !== 1'b1) $display("[TB] FAIL mid_rst_cs_n: got %b required 1", cs_n); else n_pass++;
    n_checks++; if (sck !== 1'b0) $display("[TB] FAIL mid_rst_sck: got %b required 0", sck); else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (wb.ack === 1'b1) acks++;
    end
    n_checks++; if (acks !== 0) $display("[TB] FAIL mid_rst_no_ack: got %0d acks required 0", acks); else n_pass++;
    n_checks++; if (wb.rdt !== 32'h0) $display("[TB] FAIL mid_rst_rdt: got %h required 0", wb.rdt); else n_pass++;
    wb_access(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
    n_checks++; if (rd !== 32'hDEADBEEF || lat !== 131) $display("[TB] FAIL mid_rst_recover: got %h/%0d required deadbeef/131", rd, lat); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] first;
    int lat;
    @(negedge clk);
    wb.we = 1'b0; wb.adr = 32'h100; wb.sel = 4'h0; wb.stb = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (wb.ack !== 1'b1 && lat < 1000);
    first = wb.rdt;
    n_checks++; if (first !== 32'hDEADBEEF || lat !== 131) $display("[TB] FAIL b2b_first: got %h/%0d required deadbeef/131", first, lat); else n_pass++;
    wb.adr = 32'h104;
    @(negedge clk);
    lat = 0;
    n_checks++; if (cs_n !== 1'b1) $display("[TB] FAIL b2b_not_in_ack: cs_n=%b required 1", cs_n); else n_pass++;
    n_checks++; if (wb.rdt !== 32'hDEADBEEF) $display("[TB] FAIL b2b_rdt_held: got %h required deadbeef", wb.rdt); else n_pass++;
    do begin
      @(negedge clk);
      lat++;
    end while (wb.ack !== 1'b1 && lat < 1000);
    wb.stb = 1'b0;
    n_checks++; if (lat !== 131) $display("[TB] FAIL b2b_latency: got %0d required 131", lat); else n_pass++;
    n_checks++; if (wb.rdt !== 32'h11AA3344) $display("[TB] FAIL b2b_data: got %h required 11aa3344", wb.rdt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_split_runs();
    test_sel_zero();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
